// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM pipeline stage.
//   - word / word-address widths
//   - memory operation codes carried on ex_mem_op
//   - ISA exception codes carried on ex_exp_code / mem_exp_code
//   - bus FSM state encoding used by mem_bus_if
package mem_stage_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 30;

    localparam logic [1:0] MEM_OP_NOP = 2'd0;
    localparam logic [1:0] MEM_OP_LDW = 2'd1;
    localparam logic [1:0] MEM_OP_STW = 2'd2;

    localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
    localparam logic [2:0] ISA_EXP_UNDEF      = 3'd2;
    localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;
    localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
    localparam logic [2:0] ISA_EXP_TRAP       = 3'd5;
    localparam logic [2:0] ISA_EXP_PRV_VIO    = 3'd6;
    localparam logic [2:0] ISA_EXP_BUS_ERR    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WAIT   = 2'd3
    } bus_state_e;

endpackage

// File: rtl/mem_bus_if.sv
// mem_bus_if: bus master for the MEM stage.
//   Holds the IDLE/REQ/ACCESS/WAIT FSM, the read buffer, the busy
//   request and all registered bus outputs. Flops update on the falling
//   edge of clk; reset is asynchronous, active-high.
// Optional feature (macro MEM_STAGE_BUS_TIMEOUT_EN): ACCESS gives up
//   after TIMEOUT_CYC cycles without ready and reports bus_err.
// Ports:
//   clk, reset           clock / async reset
//   stall, flush         global pipeline controls
//   start                aligned, valid load/store present in EX/MEM
//   is_load, addr,
//   wr_data              access description, sampled at grant
//   busy                 combinational stall request
//   in_wait              FSM in WAIT (load data comes from rd_buf)
//   bus_err              access ended by timeout (always 0 without macro)
//   rd_buf               captured read data
//   bus_*                req/grant/strobe/ready bus master interface
module mem_bus_if
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              start,
    input  logic              is_load,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              in_wait,
    output logic              bus_err,
    output logic [WORD_W-1:0] rd_buf,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wr_data,
    input  logic              bus_rdy_,
    input  logic [WORD_W-1:0] bus_rd_data
);

    bus_state_e state_reg, state_next;
    logic       rdy_now;
    logic       to_hit;
    logic       exit_access;

    assign rdy_now = (state_reg == ST_ACCESS) && !bus_rdy_;
    assign in_wait = (state_reg == ST_WAIT);

`ifdef MEM_STAGE_BUS_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_reg;
    logic            err_reg;

    // Fires in the TIMEOUT_CYC-th ACCESS cycle still lacking ready.
    assign to_hit  = (state_reg == ST_ACCESS) && bus_rdy_ &&
                     (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
    // Error must survive a WAIT so the MEM/WB register still sees it.
    assign bus_err = to_hit || (in_wait && err_reg);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (state_reg != ST_ACCESS)
                to_cnt_reg <= '0;
            else if (bus_rdy_)
                to_cnt_reg <= to_cnt_reg + 1'b1;
            if (to_hit)
                err_reg <= 1'b1;
            else if (!in_wait)
                err_reg <= 1'b0;
        end
    end
`else
    localparam int unused_to_cfg = TIMEOUT_CYC + TO_W;
    assign to_hit  = 1'b0;
    assign bus_err = 1'b0;
`endif

    // Timeout leaves ACCESS through the same path as a normal ready.
    assign exit_access = rdy_now || to_hit;

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    busy       = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                busy = 1'b1;
                if (flush)
                    state_next = ST_IDLE;
                else if (!bus_grnt_)
                    state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (exit_access)
                    state_next = stall ? ST_WAIT : ST_IDLE;
                else
                    busy = 1'b1;
            end
            ST_WAIT: begin
                if (!stall)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rd_buf      <= '0;
        end else begin
            state_reg <= state_next;
            // Strobe is a single-cycle pulse: low only in the edge after grant.
            bus_as_   <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (start)
                        bus_req_ <= 1'b0;
                end
                ST_REQ: begin
                    if (flush) begin
                        bus_req_ <= 1'b1;
                    end else if (!bus_grnt_) begin
                        bus_as_     <= 1'b0;
                        bus_addr    <= addr;
                        bus_rw      <= is_load;
                        bus_wr_data <= wr_data;
                    end
                end
                ST_ACCESS: begin
                    if (exit_access)
                        bus_req_ <= 1'b1;
                    if (rdy_now)
                        rd_buf <= bus_rd_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage (consumer of EX/MEM, producer of MEM/WB).
//   Checks word alignment, runs load/store through mem_bus_if, selects
//   load data and registers the MEM/WB bundle. Flops update on the falling
//   edge of clk; reset is asynchronous, active-high.
// Optional feature macro: MEM_STAGE_BUS_TIMEOUT_EN (bus timeout -> BUS_ERR).
// Ports:
//   clk, reset, stall, flush   clock, async reset, pipeline controls
//   busy                       combinational stall request to controller
//   ex_*                       EX/MEM register contents
//   bus_*                      bus master interface (active-low _ signals)
//   mem_*                      MEM/WB register outputs
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    output logic              busy,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_en,
    input  logic              ex_br_flag,
    input  logic [1:0]        ex_mem_op,
    input  logic [WORD_W-1:0] ex_mem_wr_data,
    input  logic [1:0]        ex_ctrl_op,
    input  logic [4:0]        ex_dst_addr,
    input  logic              ex_gpr_we_,
    input  logic [2:0]        ex_exp_code,
    input  logic [WORD_W-1:0] ex_out,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wr_data,
    input  logic              bus_rdy_,
    input  logic [WORD_W-1:0] bus_rd_data,
    output logic [ADDR_W-1:0] mem_pc,
    output logic              mem_en,
    output logic              mem_br_flag,
    output logic [1:0]        mem_ctrl_op,
    output logic [4:0]        mem_dst_addr,
    output logic              mem_gpr_we_,
    output logic [2:0]        mem_exp_code,
    output logic [WORD_W-1:0] mem_out
);

    logic              is_load;
    logic              access;
    logic              miss_align;
    logic              in_wait;
    logic              bus_err;
    logic [WORD_W-1:0] rd_buf;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] wb_out;

    assign is_load    = (ex_mem_op == MEM_OP_LDW);
    assign access     = ex_en && (is_load || ex_mem_op == MEM_OP_STW) &&
                        (ex_exp_code == ISA_EXP_NO_EXP) && !flush;
    assign miss_align = access && (ex_out[1:0] != 2'b00);

    mem_bus_if #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_bus_if (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .start       (access && !miss_align),
        .is_load     (is_load),
        .addr        (ex_out[WORD_W-1:2]),
        .wr_data     (ex_mem_wr_data),
        .busy        (busy),
        .in_wait     (in_wait),
        .bus_err     (bus_err),
        .rd_buf      (rd_buf),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rdy_    (bus_rdy_),
        .bus_rd_data (bus_rd_data)
    );

    // Live bus data in the ready cycle, the buffered copy once in WAIT.
    assign load_data = in_wait ? rd_buf : bus_rd_data;
    // A timed-out load has no data; report the faulting address instead.
    assign wb_out    = (is_load && !bus_err) ? load_data : ex_out;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            mem_pc       <= '0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= '0;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= ISA_EXP_NO_EXP;
            mem_out      <= '0;
        end else if (!stall) begin
            if (flush) begin
                mem_pc       <= '0;
                mem_en       <= 1'b0;
                mem_br_flag  <= 1'b0;
                mem_ctrl_op  <= '0;
                mem_dst_addr <= '0;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= ISA_EXP_NO_EXP;
                mem_out      <= '0;
            end else if (miss_align) begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= '0;
                mem_dst_addr <= '0;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= ISA_EXP_MISS_ALIGN;
                mem_out      <= '0;
            end else begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= ex_ctrl_op;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= ex_gpr_we_ | bus_err;
                mem_exp_code <= bus_err ? ISA_EXP_BUS_ERR : ex_exp_code;
                mem_out      <= wb_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. Expected MEM/WB bundles
// are queued when an instruction is driven and compared when the stage
// releases it. Active clock edge is the falling edge; outputs are read
// #1 after it or at the rising edge.
module tb_mem_stage;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we;
        logic [2:0]  code;
        logic [31:0] out;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset, ext_stall, flush, stall, busy;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_we_;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic [2:0]  ex_exp_code;
    logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    int checks = 0;
    int failures = 0;
    wb_t exp_q[$];
    wb_t exp_w, got;

    // results of the last run_op
    int          r_busy, r_ncyc, r_as, r_req, r_done;
    logic [29:0] r_addr;
    logic        r_rw;
    logic [31:0] r_wdata;

    always #5 clk = ~clk;
    // Pipeline controller: the stage's own busy plus any external stall.
    assign stall = busy | ext_stall;

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rdy_(bus_rdy_),
        .bus_rd_data(bus_rd_data),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out)
    );

    function automatic wb_t get_wb();
        return {mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out};
    endfunction

    function automatic wb_t mk_wb(input logic [29:0] pc, input logic en, input logic br,
                                  input logic [1:0] ctrl, input logic [4:0] dst, input logic we,
                                  input logic [2:0] code, input logic [31:0] out);
        return {pc, en, br, ctrl, dst, we, code, out};
    endfunction

    localparam wb_t WB_RESET = {30'd0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0};

    task automatic set_ex(input logic [1:0] op, input logic [31:0] out, input logic [31:0] wd,
                          input logic [29:0] pc, input logic [4:0] dst, input logic we,
                          input logic [1:0] ctrl, input logic br, input logic en, input logic [2:0] code);
        ex_mem_op = op; ex_out = out; ex_mem_wr_data = wd; ex_pc = pc; ex_dst_addr = dst;
        ex_gpr_we_ = we; ex_ctrl_op = ctrl; ex_br_flag = br; ex_en = en; ex_exp_code = code;
    endtask

    // Runs the currently driven instruction to the edge where MEM/WB
    // accepts it, acting as bus slave: grant in the grant_wait-th request
    // cycle, ready in the rdy_wait-th cycle after the strobe. The external
    // stall is held until stall_after cycles past the ready edge.
    task automatic run_op(input int grant_wait, input int rdy_wait, input int stall_after,
                          input logic [31:0] rd_data);
        int acc = 0;
        int hold = stall_after;
        logic granted = 1'b0;
        logic rdy_done = 1'b0;
        logic st, fire;
        r_busy = 0; r_ncyc = 0; r_as = 0; r_req = 0; r_done = 0;
        for (int c = 0; c < 200; c++) begin
            if (!bus_as_) begin
                r_as++; r_addr = bus_addr; r_rw = bus_rw; r_wdata = bus_wr_data; granted = 1'b1;
            end
            if (!bus_req_ && !granted) begin
                r_req++;
                bus_grnt_ = (r_req >= grant_wait) ? 1'b0 : 1'b1;
            end else begin
                bus_grnt_ = 1'b1;
            end
            if (granted && !rdy_done) begin
                acc++;
                bus_rdy_ = (acc >= rdy_wait) ? 1'b0 : 1'b1;
                bus_rd_data = rd_data;
            end else begin
                bus_rdy_ = 1'b1;
                bus_rd_data = 32'h5A5A_0000 + 32'(c);
            end
            if (rdy_done && hold > 0) hold--;
            ext_stall = ((!rdy_done && stall_after > 0) || hold > 0) ? 1'b1 : 1'b0;
            @(posedge clk);
            if (busy) r_busy++;
            st = stall;
            fire = !bus_rdy_;
            @(negedge clk); #1;
            r_ncyc++;
            if (fire) rdy_done = 1'b1;
            if (!st) begin r_done = 1; break; end
        end
        ext_stall = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        ex_en = 1'b0; ex_mem_op = 2'd0;
        checks++;
        if (r_done != 1) begin failures++; $display("FAIL run_op_timeout got=%0d cycles exp=completion", r_ncyc); end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; ext_stall = 1'b0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        set_ex(2'd0, 32'd0, 32'd0, 30'd0, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0);
        #3;
        got = get_wb();
        checks++; if (got !== WB_RESET) begin failures++; $display("FAIL reset_wb got=%h exp=%h", got, WB_RESET); end
        checks++; if ({bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data} !== {1'b1, 1'b1, 1'b1, 30'd0, 32'd0}) begin
            failures++; $display("FAIL reset_bus got=%b%b%b %h %h exp=111 0 0", bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); #1;
        $display("txn reset");
    endtask

    task automatic test_load();
        set_ex(2'd1, 32'h0000_0100, 32'h0, 30'h0000123, 5'd5, 1'b0, 2'd1, 1'b1, 1'b1, 3'd0);
        exp_q.push_back(mk_wb(30'h0000123, 1'b1, 1'b1, 2'd1, 5'd5, 1'b0, 3'd0, 32'hDEADBEEF));
        run_op(2, 2, 0, 32'hDEADBEEF);
        exp_w = exp_q.pop_front(); got = get_wb();
        checks++; if (got !== exp_w) begin failures++; $display("FAIL load_wb got=%h exp=%h", got, exp_w); end
        checks++; if (r_addr !== 30'h40 || r_rw !== 1'b1) begin failures++; $display("FAIL load_bus got=addr %h rw %b exp=addr 40 rw 1", r_addr, r_rw); end
        checks++; if (r_busy != 4) begin failures++; $display("FAIL load_busy got=%0d exp=4", r_busy); end
        checks++; if (r_as != 1) begin failures++; $display("FAIL load_strobes got=%0d exp=1", r_as); end
        checks++; if (bus_req_ !== 1'b1) begin failures++; $display("FAIL load_req_release got=%b exp=1", bus_req_); end
        $display("txn LDW pc=%h out=%h busy=%0d", mem_pc, mem_out, r_busy);
    endtask

    task automatic test_store();
        set_ex(2'd2, 32'h0000_0204, 32'h12345678, 30'h0000200, 5'd0, 1'b1, 2'd0, 1'b0, 1'b1, 3'd0);
        exp_q.push_back(mk_wb(30'h0000200, 1'b1, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0000_0204));
        run_op(1, 1, 0, 32'hFFFF_FFFF);
        exp_w = exp_q.pop_front(); got = get_wb();
        checks++; if (got !== exp_w) begin failures++; $display("FAIL store_wb got=%h exp=%h", got, exp_w); end
        checks++; if (r_as != 1 || r_rw !== 1'b0 || r_wdata !== 32'h12345678 || r_addr !== 30'h81) begin
            failures++; $display("FAIL store_bus got=as %0d rw %b data %h addr %h exp=as 1 rw 0 data 12345678 addr 81", r_as, r_rw, r_wdata, r_addr);
        end
        checks++; if (r_busy != 2) begin failures++; $display("FAIL store_busy got=%0d exp=2", r_busy); end
        $display("txn STW pc=%h out=%h", mem_pc, mem_out);
    endtask

    task automatic test_misalign();
        set_ex(2'd1, 32'h0000_0102, 32'h0, 30'h0000300, 5'd7, 1'b0, 2'd2, 1'b1, 1'b1, 3'd0);
        exp_q.push_back(mk_wb(30'h0000300, 1'b1, 1'b1, 2'd0, 5'd0, 1'b1, 3'd4, 32'd0));
        run_op(1, 1, 0, 32'h0);
        exp_w = exp_q.pop_front(); got = get_wb();
        checks++; if (got !== exp_w) begin failures++; $display("FAIL misalign_wb got=%h exp=%h", got, exp_w); end
        checks++; if (r_req != 0 || r_as != 0 || r_busy != 0) begin
            failures++; $display("FAIL misalign_bus got=req %0d as %0d busy %0d exp=0 0 0", r_req, r_as, r_busy);
        end
        $display("txn LDW-misaligned pc=%h code=%0d", mem_pc, mem_exp_code);
    endtask

    task automatic test_back_to_back();
        logic [31:0] out;
        logic [29:0] pc;
        logic [4:0]  dst;
        logic [1:0]  ctrl;
        for (int i = 0; i < 6; i++) begin
            out = $urandom; pc = 30'($urandom); dst = 5'($urandom); ctrl = 2'($urandom);
            set_ex((i % 2 == 1) ? 2'd3 : 2'd0, out, 32'h0, pc, dst, i[0], ctrl, i[1], 1'b1, 3'd0);
            exp_q.push_back(mk_wb(pc, 1'b1, i[1], ctrl, dst, i[0], 3'd0, out));
            run_op(1, 1, 0, 32'h0);
            exp_w = exp_q.pop_front(); got = get_wb();
            checks++; if (got !== exp_w) begin failures++; $display("FAIL alu_wb[%0d] got=%h exp=%h", i, got, exp_w); end
            checks++; if (r_ncyc != 1 || r_busy != 0) begin failures++; $display("FAIL alu_latency[%0d] got=%0d edges busy %0d exp=1 edge busy 0", i, r_ncyc, r_busy); end
            $display("txn ALU pc=%h out=%h", mem_pc, mem_out);
        end
        // Invalid store and a store carrying an upstream exception: no bus access.
        set_ex(2'd2, 32'h0000_0401, 32'h1, 30'h0000400, 5'd3, 1'b1, 2'd1, 1'b0, 1'b0, 3'd0);
        exp_q.push_back(mk_wb(30'h0000400, 1'b0, 1'b0, 2'd1, 5'd3, 1'b1, 3'd0, 32'h0000_0401));
        run_op(1, 1, 0, 32'h0);
        exp_w = exp_q.pop_front(); got = get_wb();
        checks++; if (got !== exp_w || r_as != 0) begin failures++; $display("FAIL stw_disabled got=%h as %0d exp=%h as 0", got, r_as, exp_w); end
        set_ex(2'd2, 32'h0000_0502, 32'h1, 30'h0000500, 5'd4, 1'b1, 2'd3, 1'b1, 1'b1, 3'd3);
        exp_q.push_back(mk_wb(30'h0000500, 1'b1, 1'b1, 2'd3, 5'd4, 1'b1, 3'd3, 32'h0000_0502));
        run_op(1, 1, 0, 32'h0);
        exp_w = exp_q.pop_front(); got = get_wb();
        checks++; if (got !== exp_w || r_as != 0) begin failures++; $display("FAIL stw_exception got=%h as %0d exp=%h as 0", got, r_as, exp_w); end
        $display("txn STW-exception pc=%h code=%0d", mem_pc, mem_exp_code);
    endtask

    task automatic test_stall_wait();
        set_ex(2'd1, 32'h0000_0600, 32'h0, 30'h0000600, 5'd9, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0);
        exp_q.push_back(mk_wb(30'h0000600, 1'b1, 1'b0, 2'd0, 5'd9, 1'b0, 3'd0, 32'hCAFEF00D));
        run_op(1, 1, 3, 32'hCAFEF00D);
        exp_w = exp_q.pop_front(); got = get_wb();
        checks++; if (got !== exp_w) begin failures++; $display("FAIL stall_wb got=%h exp=%h", got, exp_w); end
        checks++; if (r_as != 1) begin failures++; $display("FAIL stall_strobes got=%0d exp=1", r_as); end
        checks++; if (r_busy != 2) begin failures++; $display("FAIL stall_busy got=%0d exp=2", r_busy); end
        checks++; if (r_ncyc != 6) begin failures++; $display("FAIL stall_edges got=%0d exp=6", r_ncyc); end
        $display("txn LDW-stalled pc=%h out=%h", mem_pc, mem_out);
    endtask

    task automatic test_flush();
        set_ex(2'd1, 32'h0000_0100, 32'h0, 30'h0000077, 5'd2, 1'b0, 2'd1, 1'b1, 1'b1, 3'd0);
        exp_q.push_back(WB_RESET);
        bus_grnt_ = 1'b1;
        @(posedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_idle got=%b exp=1", busy); end
        @(negedge clk); #1;
        checks++; if (bus_req_ !== 1'b0) begin failures++; $display("FAIL flush_req_asserted got=%b exp=0", bus_req_); end
        flush = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus_req_ !== 1'b1) begin failures++; $display("FAIL flush_req_release got=%b exp=1", bus_req_); end
        @(negedge clk); #1;
        exp_w = exp_q.pop_front(); got = get_wb();
        checks++; if (got !== exp_w) begin failures++; $display("FAIL flush_bubble got=%h exp=%h", got, exp_w); end
        checks++; if (bus_as_ !== 1'b1) begin failures++; $display("FAIL flush_no_strobe got=%b exp=1", bus_as_); end
        flush = 1'b0; ex_en = 1'b0; ex_mem_op = 2'd0;
        $display("txn flush-in-REQ bubble");
    endtask

    task automatic test_reset_mid();
        // Put a known non-reset value into MEM/WB first.
        set_ex(2'd0, 32'h1111_2222, 32'h0, 30'h0000ABC, 5'd6, 1'b0, 2'd2, 1'b1, 1'b1, 3'd0);
        run_op(1, 1, 0, 32'h0);
        set_ex(2'd1, 32'h0000_0300, 32'h0, 30'h0000700, 5'd8, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0);
        exp_q.push_back(WB_RESET);
        bus_grnt_ = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++; if (bus_as_ !== 1'b0 || bus_addr !== 30'hC0) begin failures++; $display("FAIL rst_mid_access got=as %b addr %h exp=as 0 addr c0", bus_as_, bus_addr); end
        #2 reset = 1'b1;
        #1;
        exp_w = exp_q.pop_front(); got = get_wb();
        checks++; if (got !== exp_w) begin failures++; $display("FAIL rst_mid_wb got=%h exp=%h", got, exp_w); end
        checks++; if ({bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data} !== {1'b1, 1'b1, 1'b1, 30'd0, 32'd0}) begin
            failures++; $display("FAIL rst_mid_bus got=%b%b%b %h %h exp=111 0 0", bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data);
        end
        ex_en = 1'b0; ex_mem_op = 2'd0; bus_grnt_ = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus_req_ !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_no_retry got=req %b busy %b exp=req 1 busy 0", bus_req_, busy); end
        $display("txn reset-in-ACCESS");
    endtask

`ifdef MEM_STAGE_BUS_TIMEOUT_EN
    task automatic test_timeout();
        set_ex(2'd1, 32'h0000_0800, 32'h0, 30'h0000800, 5'd10, 1'b0, 2'd1, 1'b0, 1'b1, 3'd0);
        exp_q.push_back(mk_wb(30'h0000800, 1'b1, 1'b0, 2'd1, 5'd10, 1'b1, 3'd7, 32'h0000_0800));
        run_op(1, 1000, 0, 32'h0);
        exp_w = exp_q.pop_front(); got = get_wb();
        checks++; if (got !== exp_w) begin failures++; $display("FAIL timeout_wb got=%h exp=%h", got, exp_w); end
        checks++; if (r_busy != 17) begin failures++; $display("FAIL timeout_busy got=%0d exp=17", r_busy); end
        checks++; if (bus_req_ !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL timeout_release got=req %b busy %b exp=1 0", bus_req_, busy); end
        $display("txn LDW-timeout code=%0d", mem_exp_code);
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_back_to_back();
        test_stall_wait();
        test_flush();
        test_reset_mid();
`ifdef MEM_STAGE_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
